// File: rtl/nff_sync_filter.sv
// Multi-bit input synchroniser with a per-channel stability filter and optional edge pulses.
// Define NFF_SYNC_EDGE_EN to build the rise_p/fall_p/changed flops; otherwise they read as 0.
module nff_sync_filter #(
    parameter int unsigned       WIDTH      = 6,
    parameter int unsigned       STAGES     = 2,
    parameter int unsigned       FILTER_LEN = 4,
    parameter logic [WIDTH-1:0]  RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] rise_p,
    output logic [WIDTH-1:0] fall_p,
    output logic             changed
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("nff_sync_filter: STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("nff_sync_filter: FILTER_LEN must be >= 1");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level_q, level_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < int'(STAGES); n++) begin
                sync_q[n] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= in_d;
            for (int n = 1; n < int'(STAGES); n++) begin
                sync_q[n] <= sync_q[n-1];
            end
        end
    end

    assign sync = sync_q[STAGES-1];

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= RST_VAL;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_d = level_q;

`ifdef NFF_SYNC_EDGE_EN
    logic [WIDTH-1:0] rise_q, fall_q;
    logic             changed_q;
    logic [WIDTH-1:0] rise_d, fall_d;

    // Pulses land on the same edge that loads the new level.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign rise_p  = rise_q;
    assign fall_p  = fall_q;
    assign changed = changed_q;
`else
    assign rise_p  = '0;
    assign fall_p  = '0;
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_nff_sync_filter.sv
// Directed bench for nff_sync_filter: default instance plus a STAGES=3/FILTER_LEN=1/RST_VAL=3F one.
module tb_nff_sync_filter;

`ifdef NFF_SYNC_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic [5:0] in_d;
    logic [5:0] in2;
    logic [5:0] out_d, rise_p, fall_p;
    logic       changed;
    logic [5:0] out2, rise2, fall2;
    logic       changed2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nff_sync_filter dut (
        .clk     (clk),
        .rst     (rst),
        .in_d    (in_d),
        .out_d   (out_d),
        .rise_p  (rise_p),
        .fall_p  (fall_p),
        .changed (changed)
    );

    nff_sync_filter #(
        .WIDTH      (6),
        .STAGES     (3),
        .FILTER_LEN (1),
        .RST_VAL    (6'h3F)
    ) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .in_d    (in2),
        .out_d   (out2),
        .rise_p  (rise2),
        .fall_p  (fall2),
        .changed (changed2)
    );

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse expectations collapse to zero when the edge flops are not built.
    task automatic chk_main(input string tag, input logic [5:0] eo, input logic [5:0] er,
                            input logic [5:0] ef);
        logic [5:0] xr, xf;
        xr = EdgeEn ? er : 6'b0;
        xf = EdgeEn ? ef : 6'b0;
        chk({tag, ".out"}, out_d, eo);
        chk({tag, ".rise"}, rise_p, xr);
        chk({tag, ".fall"}, fall_p, xf);
        chk({tag, ".chg"}, {5'b0, changed}, {5'b0, |(xr | xf)});
    endtask

    task automatic step(input string tag, input logic [5:0] eo, input logic [5:0] er,
                        input logic [5:0] ef);
        tick();
        chk_main(tag, eo, er, ef);
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        in_d = 6'b110011;
        in2  = 6'h00;
        #1;
        chk_main("rst", 6'b000000, 6'b0, 6'b0);
        chk("rst2.out", out2, 6'h3F);
        chk("rst2.fall", fall2, 6'h00);
        #5;
        rst  = 1'b0;
        rst2 = 1'b0;

        // Scenario 1 and 5 share the release edge.
        for (int e = 1; e <= 5; e++) begin
            step("s1.wait", 6'b000000, 6'b0, 6'b0);
            if (e == 3) begin
                chk("s5.e3.out", out2, 6'h3F);
            end
            if (e == 4) begin
                chk("s5.e4.out", out2, 6'h00);
                chk("s5.e4.fall", fall2, EdgeEn ? 6'h3F : 6'h00);
                chk("s5.e4.chg", {5'b0, changed2}, {5'b0, EdgeEn});
                chk("s5.e4.rise", rise2, 6'h00);
            end
            if (e == 5) begin
                chk("s5.e5.fall", fall2, 6'h00);
                chk("s5.e5.out", out2, 6'h00);
            end
        end
        step("s1.e6", 6'b110011, 6'b110011, 6'b0);
        step("s1.e7", 6'b110011, 6'b0, 6'b0);

        // Scenario 2a: 2-cycle glitch on bit0 is rejected.
        in_d = 6'b110010;
        tick();
        tick();
        in_d = 6'b110011;
        for (int e = 0; e < 6; e++) begin
            step("s2.glitch", 6'b110011, 6'b0, 6'b0);
        end

        // Scenario 2b: exactly 4 cycles low is accepted, then the return high is too.
        in_d = 6'b110010;
        for (int e = 1; e <= 4; e++) begin
            step("s2.low", 6'b110011, 6'b0, 6'b0);
        end
        in_d = 6'b110011;
        step("s2.e5", 6'b110011, 6'b0, 6'b0);
        step("s2.e6", 6'b110010, 6'b0, 6'b000001);
        step("s2.e7", 6'b110010, 6'b0, 6'b0);
        step("s2.e8", 6'b110010, 6'b0, 6'b0);
        step("s2.e9", 6'b110010, 6'b0, 6'b0);
        step("s2.e10", 6'b110011, 6'b000001, 6'b0);
        step("s2.e11", 6'b110011, 6'b0, 6'b0);

        // Scenario 3: simultaneous falls and a rise on one edge.
        in_d = 6'b000111;
        for (int e = 1; e <= 5; e++) begin
            step("s3.wait", 6'b110011, 6'b0, 6'b0);
        end
        step("s3.e6", 6'b000111, 6'b000100, 6'b110000);
        step("s3.e7", 6'b000111, 6'b0, 6'b0);

        // Scenario 4: reset while a change is mid-filter.
        in_d = 6'b111000;
        for (int e = 1; e <= 4; e++) begin
            step("s4.pend", 6'b000111, 6'b0, 6'b0);
        end
        #3;
        rst = 1'b1;
        #1;
        chk_main("s4.async", 6'b000000, 6'b0, 6'b0);
        step("s4.hold1", 6'b000000, 6'b0, 6'b0);
        step("s4.hold2", 6'b000000, 6'b0, 6'b0);
        #4;
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step("s4.wait", 6'b000000, 6'b0, 6'b0);
        end
        step("s4.e6", 6'b111000, 6'b111000, 6'b0);
        step("s4.e7", 6'b111000, 6'b0, 6'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
